// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the fetch requester (i_*) and the
//   load/store requester (d_*). Only one transaction is in flight at a time.
//   Data requests normally win. Fetch wins once it has waited through
//   MAX_D_STREAK back-to-back data grants. Read data goes back to the
//   requester that owns the transaction.
//
// Ports
//   clock, reset       system clock; asynchronous active-low reset
//   i_read/i_address   fetch request (held until i_ready)
//   i_ready/i_valid    1-cycle accept / read-data-valid pulses to fetch
//   i_data_out         fetch read data (holds between valid pulses)
//   d_read/d_write     load/store request (held until d_ready); both = write
//   d_address/d_data_in/d_byte_en  load/store address, store data, enables
//   d_ready/d_valid    1-cycle accept / load-data-valid pulses
//   d_data_out         load data (holds between valid pulses)
//   m_read/m_write     memory strobes, held until m_ready is sampled
//   m_address/m_data_in/m_byte_en  registered memory request fields
//   m_ready/m_valid/m_data_out     memory accept, read valid, read data
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_read,
  input  logic [ADDRESS_BITS-1:0]   i_address,
  output logic                      i_ready,
  output logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     i_data_out,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDRESS_BITS-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]     d_data_in,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  output logic                      d_ready,
  output logic                      d_valid,
  output logic [DATA_WIDTH-1:0]     d_data_out,
  output logic                      m_read,
  output logic                      m_write,
  output logic [ADDRESS_BITS-1:0]   m_address,
  output logic [DATA_WIDTH-1:0]     m_data_in,
  output logic [DATA_WIDTH/8-1:0]   m_byte_en,
  input  logic                      m_ready,
  input  logic                      m_valid,
  input  logic [DATA_WIDTH-1:0]     m_data_out
);
  localparam int BE_W = DATA_WIDTH/8;
  localparam int SW   = $clog2(MAX_D_STREAK+1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic                    wr;
    logic [ADDRESS_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [BE_W-1:0]         be;
  } mreq_t;

  state_t                state_q;
  owner_t                owner_q;
  logic [SW-1:0]         streak_q, streak_d;
  mreq_t                 req_q, sel_d;
  logic                  i_ready_q, d_ready_q, i_valid_q, d_valid_q;
  logic                  m_read_q, m_write_q;
  logic [DATA_WIDTH-1:0] i_data_q, d_data_q;
  logic                  d_req, grant_i, grant_d;

  // Grant decision and the request it selects; only used from IDLE.
  always_comb begin
    d_req    = d_read | d_write;
    grant_i  = i_read & (~d_req | (streak_q == STREAK_MAX));
    grant_d  = d_req & ~grant_i;
    // Streak counts d grants that bypassed a waiting fetch; anything else
    // resets it. With streak at max and i waiting, i wins, so the guard
    // only keeps the counter from wrapping.
    streak_d = '0;
    if (grant_d && i_read && (streak_q != STREAK_MAX))
      streak_d = streak_q + SW'(1);
    sel_d = '0;
    if (grant_i) begin
      sel_d.addr = i_address;
    end else begin
      sel_d.wr   = d_write;
      sel_d.addr = d_address;
      sel_d.data = d_data_in;
      sel_d.be   = d_byte_en;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      streak_q  <= '0;
      req_q     <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i || grant_d) begin
            state_q   <= ISSUE;
            owner_q   <= grant_i ? OWN_I : OWN_D;
            streak_q  <= streak_d;
            req_q     <= sel_d;
            i_ready_q <= grant_i;
            d_ready_q <= grant_d;
            m_read_q  <= ~sel_d.wr;
            m_write_q <= sel_d.wr;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            if (req_q.wr) begin
              state_q <= IDLE;
              owner_q <= OWN_NONE;
            end else begin
              state_q <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (m_valid) begin
            if (owner_q == OWN_I) begin
              i_data_q  <= m_data_out;
              i_valid_q <= 1'b1;
            end else begin
              d_data_q  <= m_data_out;
              d_valid_q <= 1'b1;
            end
            state_q <= IDLE;
            owner_q <= OWN_NONE;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;
  assign i_valid    = i_valid_q;
  assign d_valid    = d_valid_q;
  assign i_data_out = i_data_q;
  assign d_data_out = d_data_q;
  assign m_read     = m_read_q;
  assign m_write    = m_write_q;
  assign m_address  = req_q.addr;
  assign m_data_in  = req_q.data;
  assign m_byte_en  = req_q.be;

endmodule
